// File: rtl/bus_pkg.sv
// Shared definitions for the data bus switch (daten_bus_weiche).
// Holds the I/O access FSM state encoding and the address-bit positions
// used to decode CPU data-bus accesses into RAM, output and input space.
package bus_pkg;

  // I/O access sequencer states
  typedef enum logic [1:0] {
    BEREIT  = 2'd0,  // idle, RAM accesses pass straight through
    WARTEN  = 2'd1,  // counting I/O wait cycles
    ANTWORT = 2'd2   // handshake to the CPU held until requests drop
  } zustand_t;

  // Address decoding
  localparam int IO_BIT      = 31;  // 1 = I/O space, 0 = RAM
  localparam int EINGANG_BIT = 30;  // within I/O: 1 = input channels, 0 = output registers
  localparam int KANAL_LSB   = 0;   // channel number field
  localparam int KANAL_W     = 4;

endpackage

// File: rtl/io_kanal_register.sv
// One I/O channel of the data bus switch.
// Ports:
//   Clock, Reset      system clock, synchronous active-high reset
//   SchreibFreigabe   one-cycle write strobe for the output register
//   SchreibWert       value loaded into the output register
//   Eingang           asynchronous input pins of this channel
//   Ausgang           output register
//   EingangSync       input after the two-stage synchroniser
module io_kanal_register
  import bus_pkg::*;
#(
  parameter int               BREITE     = 8,
  parameter logic [BREITE-1:0] RESET_WERT = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              SchreibFreigabe,
  input  logic [BREITE-1:0] SchreibWert,
  input  logic [BREITE-1:0] Eingang,
  output logic [BREITE-1:0] Ausgang,
  output logic [BREITE-1:0] EingangSync
);

  logic [BREITE-1:0] eingangSync_p0;
  logic [BREITE-1:0] eingangSync_p1;

  // Output register and two flip-flop synchroniser stages
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Ausgang        <= RESET_WERT;
      eingangSync_p0 <= '0;
      eingangSync_p1 <= '0;
    end else begin
      if (SchreibFreigabe) Ausgang <= SchreibWert;
      eingangSync_p0 <= Eingang;
      eingangSync_p1 <= eingangSync_p0;
    end
  end

  assign EingangSync = eingangSync_p1;

endmodule

// File: rtl/daten_bus_weiche.sv
// Data bus switch: routes CPU data accesses either to RAM (combinational
// pass-through) or to a bank of memory-mapped I/O channels handled by a
// small FSM with configurable wait cycles.
// Ports:
//   Clock, Reset                           clock, synchronous active-high reset
//   LeseDaten, SchreibeDaten               CPU read / write request levels
//   DatenAdresse, DatenRaus                CPU word address and write data
//   CPUDatenRein                           read data to the CPU
//   CPUDatenGeladen, CPUDatenGespeichert   read / write completion to the CPU
//   RAMLeseDaten, RAMSchreibeDaten         RAM requests
//   RAMDatenRein, RAMDatenGeladen,
//   RAMDatenGespeichert                    RAM response
//   Ausgang                                output channel registers (flattened)
//   Eingang                                asynchronous input channels (flattened)
module daten_bus_weiche
  import bus_pkg::*;
#(
  parameter int          KANAELE     = 4,
  parameter int          BREITE      = 8,
  parameter int          FALTMODUS   = 1,
  parameter int          WARTEZYKLEN = 1,
  parameter logic [31:0] RESET_WERT  = 32'd0
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      LeseDaten,
  input  logic                      SchreibeDaten,
  input  logic [31:0]               DatenAdresse,
  input  logic [31:0]               DatenRaus,
  output logic [31:0]               CPUDatenRein,
  output logic                      CPUDatenGeladen,
  output logic                      CPUDatenGespeichert,
  output logic                      RAMLeseDaten,
  output logic                      RAMSchreibeDaten,
  input  logic [31:0]               RAMDatenRein,
  input  logic                      RAMDatenGeladen,
  input  logic                      RAMDatenGespeichert,
  output logic [KANAELE*BREITE-1:0] Ausgang,
  input  logic [KANAELE*BREITE-1:0] Eingang
);

  localparam logic [3:0] ZAEHL_ENDE = (WARTEZYKLEN == 0) ? 4'd0 : 4'(WARTEZYKLEN - 1);

  // In fold mode the four bytes are OR-ed together, so a byte store from the
  // CPU lands on the channel whatever its byte lane.
  function automatic logic [BREITE-1:0] schreibWertBilden(input logic [31:0] d);
    logic [7:0]  oder;
    logic [31:0] breit;
    oder  = d[31:24] | d[23:16] | d[15:8] | d[7:0];
    breit = (FALTMODUS != 0) ? {24'd0, oder} : d;
    return breit[BREITE-1:0];
  endfunction

  zustand_t               zustand;
  logic [3:0]             zaehler;
  logic [KANAL_W-1:0]     kanalReg;
  logic                   eingangSelReg;
  logic                   istSchreibenReg;
  logic [BREITE-1:0]      wertReg;
  logic [31:0]            ioDaten;
  logic                   ioGeladen;
  logic                   ioGespeichert;

  logic                   ioAnfrage;
  logic                   ramDurchgang;
  logic                   eintritt;
  logic [KANAL_W-1:0]     opKanal;
  logic                   opEingang;
  logic                   opSchreiben;
  logic [BREITE-1:0]      opWert;
  logic [31:0]            leseWert;
  logic [KANAELE*BREITE-1:0] eingangSync;
  logic                   unusedAdressBits;

  assign unusedAdressBits = ^DatenAdresse[EINGANG_BIT-1:KANAL_LSB+KANAL_W];

  assign ioAnfrage    = (LeseDaten | SchreibeDaten) & DatenAdresse[IO_BIT];
  assign ramDurchgang = (zustand == BEREIT) & ~DatenAdresse[IO_BIT];

  // With zero wait cycles the access completes on the request edge itself,
  // so the operation comes straight from the bus; otherwise from the latch.
  always_comb begin
    opKanal     = kanalReg;
    opEingang   = eingangSelReg;
    opSchreiben = istSchreibenReg;
    opWert      = wertReg;
    eintritt    = 1'b0;
    if (zustand == BEREIT) begin
      opKanal     = DatenAdresse[KANAL_LSB +: KANAL_W];
      opEingang   = DatenAdresse[EINGANG_BIT];
      opSchreiben = SchreibeDaten;
      opWert      = schreibWertBilden(DatenRaus);
      eintritt    = ioAnfrage && (WARTEZYKLEN == 0);
    end else if (zustand == WARTEN) begin
      eintritt    = (zaehler == ZAEHL_ENDE);
    end
  end

  // Channels beyond KANAELE have no register and read as zero
  always_comb begin
    leseWert = 32'd0;
    for (int i = 0; i < KANAELE; i++) begin
      if (opKanal == 4'(i)) begin
        leseWert = opEingang ? 32'(eingangSync[i*BREITE +: BREITE])
                             : 32'(Ausgang[i*BREITE +: BREITE]);
      end
    end
  end

  for (genvar i = 0; i < KANAELE; i++) begin : gKanal
    io_kanal_register #(
      .BREITE     (BREITE),
      .RESET_WERT (RESET_WERT[BREITE-1:0])
    ) uKanal (
      .Clock           (Clock),
      .Reset           (Reset),
      .SchreibFreigabe (eintritt & opSchreiben & (opKanal == 4'(i))),
      .SchreibWert     (opWert),
      .Eingang         (Eingang[i*BREITE +: BREITE]),
      .Ausgang         (Ausgang[i*BREITE +: BREITE]),
      .EingangSync     (eingangSync[i*BREITE +: BREITE])
    );
  end

  // Request latch: captures the access when it is accepted in BEREIT
  always_ff @(posedge Clock) begin
    if (zustand == BEREIT && ioAnfrage) begin
      kanalReg        <= DatenAdresse[KANAL_LSB +: KANAL_W];
      eingangSelReg   <= DatenAdresse[EINGANG_BIT];
      istSchreibenReg <= SchreibeDaten;
      wertReg         <= schreibWertBilden(DatenRaus);
    end
  end

  // Access sequencer with registered handshakes
  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand       <= BEREIT;
      zaehler       <= 4'd0;
      ioDaten       <= 32'd0;
      ioGeladen     <= 1'b0;
      ioGespeichert <= 1'b0;
    end else if (eintritt) begin
      zustand       <= ANTWORT;
      zaehler       <= 4'd0;
      ioGespeichert <= opSchreiben;
      ioGeladen     <= ~opSchreiben;
      if (!opSchreiben) ioDaten <= leseWert;
    end else begin
      case (zustand)
        BEREIT: begin
          if (ioAnfrage) begin
            zustand <= WARTEN;
            zaehler <= 4'd0;
          end
        end
        WARTEN: zaehler <= zaehler + 4'd1;
        ANTWORT: begin
          if (!LeseDaten && !SchreibeDaten) begin
            zustand       <= BEREIT;
            ioGeladen     <= 1'b0;
            ioGespeichert <= 1'b0;
          end
        end
        default: zustand <= BEREIT;
      endcase
    end
  end

  assign RAMLeseDaten        = ramDurchgang & LeseDaten;
  assign RAMSchreibeDaten    = ramDurchgang & SchreibeDaten;
  assign CPUDatenRein        = ramDurchgang ? RAMDatenRein        : ioDaten;
  assign CPUDatenGeladen     = ramDurchgang ? RAMDatenGeladen     : ioGeladen;
  assign CPUDatenGespeichert = ramDurchgang ? RAMDatenGespeichert : ioGespeichert;

endmodule

// File: tb/tb_daten_bus_weiche.sv
// Directed bench for daten_bus_weiche with default parameters
// (4 channels, 8 bits, fold mode, one wait cycle, reset value 0).
module tb_daten_bus_weiche;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        LeseDaten, SchreibeDaten;
  logic [31:0] DatenAdresse, DatenRaus;
  logic [31:0] CPUDatenRein;
  logic        CPUDatenGeladen, CPUDatenGespeichert;
  logic        RAMLeseDaten, RAMSchreibeDaten;
  logic [31:0] RAMDatenRein;
  logic        RAMDatenGeladen, RAMDatenGespeichert;
  logic [31:0] Ausgang;
  logic [31:0] Eingang;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  daten_bus_weiche dut (
    .Clock               (Clock),
    .Reset               (Reset),
    .LeseDaten           (LeseDaten),
    .SchreibeDaten       (SchreibeDaten),
    .DatenAdresse        (DatenAdresse),
    .DatenRaus           (DatenRaus),
    .CPUDatenRein        (CPUDatenRein),
    .CPUDatenGeladen     (CPUDatenGeladen),
    .CPUDatenGespeichert (CPUDatenGespeichert),
    .RAMLeseDaten        (RAMLeseDaten),
    .RAMSchreibeDaten    (RAMSchreibeDaten),
    .RAMDatenRein        (RAMDatenRein),
    .RAMDatenGeladen     (RAMDatenGeladen),
    .RAMDatenGespeichert (RAMDatenGespeichert),
    .Ausgang             (Ausgang),
    .Eingang             (Eingang)
  );

  task automatic pruefe(input string tag, input logic [63:0] ist, input logic [63:0] soll);
    checks++;
    if (ist !== soll) begin
      errors++;
      $display("FAIL %s ist=0x%0h soll=0x%0h", tag, ist, soll);
    end
  endtask

  // Full I/O transaction: request, wait for the handshake, drop, see it clear.
  task automatic ioZugriff(input string tag, input logic s, input logic l,
                           input logic [31:0] adr, input logic [31:0] d,
                           output int latenz, output logic [31:0] gelesen);
    logic gesehen;
    @(posedge Clock); #1;
    SchreibeDaten = s; LeseDaten = l; DatenAdresse = adr; DatenRaus = d;
    latenz = 0; gesehen = 1'b0;
    for (int c = 0; c < 20 && !gesehen; c++) begin
      @(posedge Clock); latenz++;
      @(negedge Clock);
      if (s ? CPUDatenGespeichert : CPUDatenGeladen) gesehen = 1'b1;
    end
    pruefe({tag, "_handshake"}, 64'(gesehen), 64'd1);
    pruefe({tag, "_ramRuhig"}, 64'({RAMLeseDaten, RAMSchreibeDaten}), 64'd0);
    if (s) pruefe({tag, "_keinGeladen"}, 64'(CPUDatenGeladen), 64'd0);
    gelesen = CPUDatenRein;
    @(posedge Clock); #1;
    SchreibeDaten = 1'b0; LeseDaten = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    pruefe({tag, "_handshakeAus"}, 64'(CPUDatenGeladen | CPUDatenGespeichert), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog ist=timeout soll=finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] rd;

    Reset = 1'b1; LeseDaten = 1'b0; SchreibeDaten = 1'b0;
    DatenAdresse = 32'h8000_0000; DatenRaus = 32'd0;
    RAMDatenRein = 32'd0; RAMDatenGeladen = 1'b0; RAMDatenGespeichert = 1'b0;
    Eingang = 32'd0;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    pruefe("reset_ausgang", 64'(Ausgang), 64'd0);
    pruefe("reset_rein", 64'(CPUDatenRein), 64'd0);
    pruefe("reset_hs", 64'({CPUDatenGeladen, CPUDatenGespeichert}), 64'd0);
    pruefe("reset_ram", 64'({RAMLeseDaten, RAMSchreibeDaten}), 64'd0);

    // Folded write to channel 0
    ioZugriff("schreib0", 1'b1, 1'b0, 32'h8000_0000, 32'h0102_0408, lat, rd);
    pruefe("schreib0_latenz", 64'(lat), 64'd2);
    pruefe("schreib0_ausgang", 64'(Ausgang), 64'h0000_000F);

    // Write held for 5 cycles in ANTWORT with changing data: one update only
    @(posedge Clock); #1;
    SchreibeDaten = 1'b1; DatenAdresse = 32'h8000_0001; DatenRaus = 32'h0000_0033;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    pruefe("halten_hs", 64'(CPUDatenGespeichert), 64'd1);
    pruefe("halten_ausgang", 64'(Ausgang), 64'h0000_330F);
    DatenRaus = 32'h0000_00CC; DatenAdresse = 32'h8000_0002;
    repeat (5) begin
      @(posedge Clock);
      @(negedge Clock);
      pruefe("halten_einmal", 64'(Ausgang), 64'h0000_330F);
      pruefe("halten_hsBleibt", 64'(CPUDatenGespeichert), 64'd1);
    end
    #1 SchreibeDaten = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    pruefe("halten_hsAus", 64'(CPUDatenGespeichert), 64'd0);
    pruefe("halten_ausgangEnde", 64'(Ausgang), 64'h0000_330F);

    // Synchronised input read, channel 2
    Eingang = 32'h00A5_0000;
    repeat (2) @(posedge Clock);
    ioZugriff("eingang2", 1'b0, 1'b1, 32'hC000_0002, 32'd0, lat, rd);
    pruefe("eingang2_latenz", 64'(lat), 64'd2);
    pruefe("eingang2_daten", 64'(rd), 64'h0000_00A5);

    // Output readback
    ioZugriff("rueck0", 1'b0, 1'b1, 32'h8000_0000, 32'd0, lat, rd);
    pruefe("rueck0_daten", 64'(rd), 64'h0000_000F);

    // Nonexistent channel 9
    ioZugriff("kanal9", 1'b1, 1'b0, 32'h8000_0009, 32'h0000_00FF, lat, rd);
    pruefe("kanal9_latenz", 64'(lat), 64'd2);
    pruefe("kanal9_ausgang", 64'(Ausgang), 64'h0000_330F);
    ioZugriff("kanal9Lesen", 1'b0, 1'b1, 32'h8000_0009, 32'd0, lat, rd);
    pruefe("kanal9_rueck", 64'(rd), 64'd0);

    // Channel 3 fold: 0x12|0x34|0x56|0x78 = 0x7E
    ioZugriff("kanal3", 1'b1, 1'b0, 32'h8000_0003, 32'h1234_5678, lat, rd);
    pruefe("kanal3_ausgang", 64'(Ausgang), 64'h7E00_330F);
    ioZugriff("kanal3Lesen", 1'b0, 1'b1, 32'h8000_0003, 32'd0, lat, rd);
    pruefe("kanal3_rueck", 64'(rd), 64'h0000_007E);

    // Both requests high: write only
    ioZugriff("beide", 1'b1, 1'b1, 32'h8000_0001, 32'h0000_0055, lat, rd);
    pruefe("beide_ausgang", 64'(Ausgang), 64'h7E00_550F);

    // RAM pass-through
    @(posedge Clock); #1;
    DatenAdresse = 32'h0000_0010; LeseDaten = 1'b1;
    RAMDatenRein = 32'hDEAD_BEEF; RAMDatenGeladen = 1'b1;
    #1;
    pruefe("ramLesen_req", 64'({RAMLeseDaten, RAMSchreibeDaten}), 64'b10);
    pruefe("ramLesen_daten", 64'(CPUDatenRein), 64'hDEAD_BEEF);
    pruefe("ramLesen_hs", 64'(CPUDatenGeladen), 64'd1);
    LeseDaten = 1'b0; SchreibeDaten = 1'b1; RAMDatenGeladen = 1'b0; RAMDatenGespeichert = 1'b1;
    #1;
    pruefe("ramSchreib_req", 64'({RAMLeseDaten, RAMSchreibeDaten}), 64'b01);
    pruefe("ramSchreib_hs", 64'({CPUDatenGeladen, CPUDatenGespeichert}), 64'b01);
    DatenAdresse = 32'h8000_0000; SchreibeDaten = 1'b0; LeseDaten = 1'b1; RAMDatenGeladen = 1'b1;
    #1;
    pruefe("ramIo_req", 64'({RAMLeseDaten, RAMSchreibeDaten}), 64'd0);
    pruefe("ramIo_hs", 64'({CPUDatenGeladen, CPUDatenGespeichert}), 64'd0);
    LeseDaten = 1'b0; RAMDatenGeladen = 1'b0; RAMDatenGespeichert = 1'b0;

    // Reset while in WARTEN
    @(posedge Clock); #1;
    SchreibeDaten = 1'b1; DatenAdresse = 32'h8000_0000; DatenRaus = 32'h0000_00AA;
    @(posedge Clock); #1;
    Reset = 1'b1; SchreibeDaten = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    pruefe("resetWarten_ausgang", 64'(Ausgang), 64'd0);
    pruefe("resetWarten_hs", 64'(CPUDatenGespeichert), 64'd0);
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    pruefe("resetWarten_keinSchreiben", 64'(Ausgang), 64'd0);
    ioZugriff("nachReset", 1'b0, 1'b1, 32'h8000_0000, 32'd0, lat, rd);
    pruefe("nachReset_latenz", 64'(lat), 64'd2);
    pruefe("nachReset_daten", 64'(rd), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/daten_bus_weiche.md
DATEN_BUS_WEICHE -- requirements
Module: daten_bus_weiche

Interface
REQ-001 SHALL have parameter KANAELE, default 4: number of I/O channels, 1..16.
REQ-002 SHALL have parameter BREITE, default 8: bits per channel, 1..32.
REQ-003 SHALL have parameter FALTMODUS, default 1: 1 = write value is the OR of the four bytes of DatenRaus (BREITE must be 8); 0 = DatenRaus[BREITE-1:0].
REQ-004 SHALL have parameter WARTEZYKLEN, default 1: I/O wait cycles before the response, 0..15.
REQ-005 SHALL have parameter RESET_WERT, default 0: reset value of every output channel.
REQ-006 Clock  in  1  single system clock; all logic on posedge.
REQ-007 Reset  in  1  synchronous, active-high.
REQ-008 LeseDaten, SchreibeDaten  in  1 each  CPU read/write request levels.
REQ-009 DatenAdresse  in  32  CPU word address; bit31=1 selects I/O, 0 selects RAM.
REQ-010 DatenRaus  in  32  CPU write data.
REQ-011 CPUDatenRein  out  32; CPUDatenGeladen, CPUDatenGespeichert  out  1 each: responses to the CPU.
REQ-012 RAMLeseDaten, RAMSchreibeDaten  out  1 each; RAMDatenRein  in  32; RAMDatenGeladen, RAMDatenGespeichert  in  1 each: RAM side.
REQ-013 Ausgang  out  KANAELE*BREITE  output channel registers; Eingang  in  KANAELE*BREITE  asynchronous input channels.

Function
REQ-014 SHALL pass a RAM access (bit31=0, FSM in BEREIT) through combinationally: RAM requests = CPU requests; CPUDatenRein = RAMDatenRein; CPU handshakes = RAM handshakes.
REQ-015 SHALL hold RAMLeseDaten and RAMSchreibeDaten at 0 during I/O accesses and whenever the FSM is not in BEREIT.
REQ-016 SHALL decode I/O accesses as follows: bit30=0 selects output register Ausgang[k]; bit30=1 selects synchronised input k; k = DatenAdresse[3:0].
REQ-017 SHALL synchronise Eingang through two flip-flop stages; a read returns the second-stage value, zero-extended to 32 bits.
REQ-018 SHALL read back the current output register, zero-extended, when the output space is read.
REQ-019 SHALL implement the FSM states BEREIT, WARTEN, ANTWORT.
REQ-020 In BEREIT, an I/O request (either request high with bit31=1) SHALL latch address, data and operation, then go to WARTEN, or directly to ANTWORT when WARTEZYKLEN=0.
REQ-021 In WARTEN, a counter SHALL run WARTEZYKLEN cycles, then the FSM SHALL go to ANTWORT.
REQ-022 On entering ANTWORT, a write SHALL update the addressed output register exactly once, and a read SHALL register CPUDatenRein.
REQ-023 In ANTWORT, CPUDatenGespeichert (write) or CPUDatenGeladen (read) SHALL be high and held until both requests are low; the FSM SHALL then return to BEREIT.
REQ-024 I/O latency from request to response SHALL be WARTEZYKLEN+1 cycles.
REQ-025 When both requests are high, the access SHALL be a write only and CPUDatenGeladen SHALL stay 0.
REQ-026 A channel k >= KANAELE SHALL ignore writes, read as 0, and still complete the handshake (no hang).
REQ-027 Request inputs and DatenAdresse SHALL be ignored while in WARTEN or ANTWORT.

Reset
REQ-028 Reset SHALL set: FSM to BEREIT, counter 0, all Ausgang channels to RESET_WERT, synchroniser stages 0, CPUDatenRein 0, I/O handshakes 0.
REQ-029 Reset asserted mid-access SHALL abort the access, with no register write after the reset edge.

Structure
REQ-030 FSM state encodings and the I/O address-bit constants (31, 30, channel field) SHALL live in a shared package, bus_pkg.
REQ-031 One sub-module, io_kanal_register (one channel: output register, write enable, 2-stage input synchroniser), SHALL be instantiated KANAELE times.

Verification
REQ-032 Write 0x01020408 to 0x80000000 with FALTMODUS=1 -> Ausgang[7:0]=0x0F; CPUDatenGespeichert high 2 cycles after the request.
REQ-033 Drive Eingang channel 2 = 0xA5, wait 2 cycles, read 0xC0000002 -> CPUDatenRein=0x000000A5, CPUDatenGeladen held until LeseDaten falls.
REQ-034 Read/write at 0x00000010 -> RAM signals mirrored in the same cycle; RAMLeseDaten=0 for all I/O addresses.
REQ-035 Write 0xFF to channel 9 with KANAELE=4 -> all Ausgang unchanged, handshake completes, readback 0.
REQ-036 Hold SchreibeDaten high for 5 cycles in ANTWORT -> exactly one register update, then BEREIT after the request drops.
REQ-037 Reset in WARTEN -> Ausgang=RESET_WERT next cycle, no write, FSM in BEREIT.
